// File: rtl/gcd_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// gcd_pkg -- shared types and constants for the GCD request scheduler.
//
// Contents:
//   GCD_W          default operand/result width
//   sched_state_t  scheduler FSM state encoding
//
// Optional feature macro: GCD_SCHED_ZERO_BYPASS_EN adds the BYPASS state,
// which answers requests that carry a zero operand without using the engine.
// -----------------------------------------------------------------------------
package gcd_pkg;

  localparam int GCD_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    DONE   = 3'd3
`ifdef GCD_SCHED_ZERO_BYPASS_EN
    ,
    BYPASS = 3'd4
`endif
  } sched_state_t;

endpackage

// File: rtl/gcd_scheduler_if.sv
// -----------------------------------------------------------------------------
// gcd_scheduler_if -- handshake between the scheduler and the external GCD
// engine.
//
// Signals:
//   gcd_start  scheduler -> engine  start strobe (one cycle)
//   gcd_ina    scheduler -> engine  operand A
//   gcd_inb    scheduler -> engine  operand B
//   gcd_ready  engine -> scheduler  engine idle, gcd_out valid
//   gcd_out    engine -> scheduler  engine result
//
// Modports:
//   master  scheduler side
//   slave   engine side
// -----------------------------------------------------------------------------
interface gcd_scheduler_if
  import gcd_pkg::*;
#(
  parameter int N = GCD_W
) ();

  logic         gcd_start;
  logic [N-1:0] gcd_ina;
  logic [N-1:0] gcd_inb;
  logic         gcd_ready;
  logic [N-1:0] gcd_out;

  modport master (
    output gcd_start,
    output gcd_ina,
    output gcd_inb,
    input  gcd_ready,
    input  gcd_out
  );

  modport slave (
    input  gcd_start,
    input  gcd_ina,
    input  gcd_inb,
    output gcd_ready,
    output gcd_out
  );

endinterface

// File: rtl/gcd_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter -- combinational round-robin pick among REQS requesters.
//
// Search starts at index last+1 (wrapping at REQS-1 back to 0) and the first
// requester found wins, so the previous winner has the lowest priority.
//
// Ports:
//   req    in   per-requester request level
//   last   in   index of the previously served requester
//   grant  out  index of the winner (0 when valid is low)
//   valid  out  at least one request is present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int REQS = 4,
  localparam int IW   = (REQS > 1) ? $clog2(REQS) : 1
) (
  input  logic [REQS-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   grant,
  output logic            valid
);

  logic [IW-1:0] w_cand;

  // Walk the requesters in rotated order and keep the first hit.
  always_comb begin
    w_cand = last;
    grant  = {IW{1'b0}};
    valid  = 1'b0;
    for (int k = 0; k < REQS; k++) begin
      // Wrap explicitly so non-power-of-two REQS never indexes past the end.
      if (w_cand == IW'(REQS - 1)) begin
        w_cand = {IW{1'b0}};
      end else begin
        w_cand = w_cand + IW'(1);
      end
      if (!valid && req[w_cand]) begin
        valid = 1'b1;
        grant = w_cand;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/gcd_scheduler.sv
// -----------------------------------------------------------------------------
// gcd_scheduler -- shares one external GCD engine among REQS requesters.
//
// A round-robin winner is picked in IDLE; its index and operands are latched
// at grant, so requesters may change opa/opb afterwards. The latched operands
// are offered to the engine in LAUNCH, the result is collected in WAIT and
// returned with a one-cycle done pulse in DONE.
//
// Parameters:
//   N      operand/result width
//   REQS   number of requesters (2..8)
//
// Ports:
//   clk     in   clock, all state changes on posedge
//   rst     in   asynchronous active-high reset
//   req     in   [REQS]    request level per requester
//   opa     in   [REQS*N]  operand A, requester i in bits [i*N +: N]
//   opb     in   [REQS*N]  operand B, packed like opa
//   done    out  [REQS]    one-cycle completion pulse to the served requester
//   result  out  [N]       GCD, valid while any done bit is high, else 0
//   busy    out            high in every state except IDLE
//   eng     master side of gcd_scheduler_if (gcd_start, gcd_ina, gcd_inb,
//           gcd_ready, gcd_out)
//
// Optional feature macro: GCD_SCHED_ZERO_BYPASS_EN -- a grant whose operand A
// or B is zero skips the engine: result = opa|opb is returned via BYPASS.
// Without it, zero operands go to the engine unchanged.
// -----------------------------------------------------------------------------
module gcd_scheduler
  import gcd_pkg::*;
#(
  parameter int N    = GCD_W,
  parameter int REQS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REQS-1:0]   req,
  input  logic [REQS*N-1:0] opa,
  input  logic [REQS*N-1:0] opb,
  output logic [REQS-1:0]   done,
  output logic [N-1:0]      result,
  output logic              busy,
  gcd_scheduler_if.master   eng
);

  localparam int IW = (REQS > 1) ? $clog2(REQS) : 1;

  sched_state_t    r_state;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   r_last;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [N-1:0]    r_result;
  logic [REQS-1:0] r_done;
  logic            r_busy;
  logic            r_wait_first;

  logic [N-1:0]    w_opa [REQS];
  logic [N-1:0]    w_opb [REQS];
  logic [IW-1:0]   w_grant;
  logic            w_valid;
  logic [REQS-1:0] w_idx_onehot;

  // Unpack the flat operand buses into per-requester words.
  for (genvar gi = 0; gi < REQS; gi++) begin : g_unpack
    assign w_opa[gi] = opa[gi*N +: N];
    assign w_opb[gi] = opb[gi*N +: N];
  end

  rr_arbiter #(
    .REQS (REQS)
  ) u_arb (
    .req   (req),
    .last  (r_last),
    .grant (w_grant),
    .valid (w_valid)
  );

  assign w_idx_onehot = {{(REQS-1){1'b0}}, 1'b1} << r_idx;

`ifdef GCD_SCHED_ZERO_BYPASS_EN
  logic w_zero_op;
  assign w_zero_op = (w_opa[w_grant] == {N{1'b0}}) ||
                     (w_opb[w_grant] == {N{1'b0}});
`endif

  // Scheduler FSM with its registered outputs and latched request context.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_idx        <= {IW{1'b0}};
      r_last       <= IW'(REQS - 1);
      r_a          <= {N{1'b0}};
      r_b          <= {N{1'b0}};
      r_result     <= {N{1'b0}};
      r_done       <= {REQS{1'b0}};
      r_busy       <= 1'b0;
      r_wait_first <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            // Operands are captured here and never re-read from opa/opb.
            r_idx  <= w_grant;
            r_a    <= w_opa[w_grant];
            r_b    <= w_opb[w_grant];
            r_busy <= 1'b1;
`ifdef GCD_SCHED_ZERO_BYPASS_EN
            if (w_zero_op) begin
              r_state <= BYPASS;
            end else begin
              r_state <= LAUNCH;
            end
`else
            r_state <= LAUNCH;
`endif
          end else begin
            r_busy <= 1'b0;
          end
        end

        LAUNCH: begin
          // gcd_start is only driven while the engine reports ready, so the
          // start is accepted on this edge exactly when ready is high.
          if (eng.gcd_ready) begin
            r_state      <= WAIT;
            r_wait_first <= 1'b1;
          end else begin
            r_state <= LAUNCH;
          end
        end

        WAIT: begin
          // The engine drops ready one cycle after start, so ready seen in
          // the first WAIT cycle still belongs to the previous operation.
          if (r_wait_first) begin
            r_wait_first <= 1'b0;
          end else if (eng.gcd_ready) begin
            r_result <= eng.gcd_out;
            r_done   <= w_idx_onehot;
            r_state  <= DONE;
          end else begin
            r_state <= WAIT;
          end
        end

`ifdef GCD_SCHED_ZERO_BYPASS_EN
        BYPASS: begin
          // gcd(x,0)=x and gcd(0,0)=0, both equal to the OR of the operands.
          r_result <= r_a | r_b;
          r_done   <= w_idx_onehot;
          r_state  <= DONE;
        end
`endif

        DONE: begin
          r_done   <= {REQS{1'b0}};
          r_result <= {N{1'b0}};
          r_last   <= r_idx;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end

        default: begin
          r_done       <= {REQS{1'b0}};
          r_result     <= {N{1'b0}};
          r_busy       <= 1'b0;
          r_wait_first <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign eng.gcd_start = (r_state == LAUNCH) && eng.gcd_ready;
  assign eng.gcd_ina   = r_a;
  assign eng.gcd_inb   = r_b;

  assign done   = r_done;
  assign result = r_result;
  assign busy   = r_busy;

endmodule
